// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray counter and its decoder.
// The conversion functions work on a 32-bit form. Callers zero-extend narrower
// values in and truncate results out, so any counter width up to 31 bits works.
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;

    // Binary to Gray: adjacent binary values differ in exactly one Gray bit.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Gray code of the all-ones binary value for a given width (only the MSB set).
    function automatic logic [31:0] gray_max(input int width);
        return bin2gray(32'hFFFF_FFFF >> (32 - width));
    endfunction

    localparam logic [GRAY_DEFAULT_WIDTH-1:0] GRAY_MAX =
        GRAY_DEFAULT_WIDTH'(gray_max(GRAY_DEFAULT_WIDTH));

endpackage

// File: rtl/gray_counter_conv_gray_to_bin.sv
// Combinational Gray-to-binary decoder (prefix XOR from the MSB down).
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each output bit is the parity of the Gray bits from its position upward.
    // NOTE: give every always_comb output a default before any branch or loop so no latch can be inferred.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_counter_conv.sv
// Gray-code up/down counter with load, wrap/saturate ends, terminal count,
// wrap pulse and a registered binary readback that trails the state by a cycle.
// WIDTH must be in the range 2..31.
module gray_counter_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             tc,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] GRAY_TOP = WIDTH'(gray_max(WIDTH));

    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_d;
    logic             at_end;
    logic             wrap_d;

    // A single decoder serves both the next-state arithmetic and the readback register.
    gray_to_bin #(.WIDTH(WIDTH)) u_decode (
        .gray (gray_out),
        .bin  (bin_cur)
    );

    // Next state: load wins, then a count step, otherwise hold. In saturate mode
    // a step off the end for the current direction is suppressed.
    always_comb begin
        bin_next = up_dn ? (bin_cur + WIDTH'(1)) : (bin_cur - WIDTH'(1));
        at_end   = up_dn ? (bin_cur == '1) : (bin_cur == '0);
        gray_d   = gray_out;
        wrap_d   = 1'b0;
        if (load) begin
            gray_d = WIDTH'(bin2gray(32'(load_bin)));
        end else if (en) begin
            if (WRAP || !at_end) begin
                gray_d = WIDTH'(bin2gray(32'(bin_next)));
                wrap_d = at_end;
            end
        end
    end

    // Terminal count depends on direction, so it stays combinational from state and up_dn.
    assign tc = up_dn ? (gray_out == GRAY_TOP) : (gray_out == '0);

    // Gray state and the wrap pulse are registered together.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_out   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            gray_out   <= gray_d;
            wrap_pulse <= wrap_d;
        end
    end

    // Readback captures the decode of the current state; it is valid only when
    // the state does not move on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out   <= '0;
            bin_valid <= 1'b0;
        end else begin
            bin_out   <= bin_cur;
            bin_valid <= (gray_d == gray_out);
        end
    end

endmodule

// File: tb/tb_gray_counter_conv.sv
// Self-checking bench for gray_counter_conv: directed 4-bit scenarios on a
// wrapping and a saturating instance, plus a randomized 8-bit run against a
// position-based reference model.
module tb_gray_counter_conv;

    logic clk = 1'b0;
    logic rst;

    // Shared stimulus for the two 4-bit instances.
    logic       en, up_dn, load;
    logic [3:0] load_bin;
    logic [3:0] gray_w, bin_w, gray_s, bin_s;
    logic       valid_w, tc_w, wrap_w, valid_s, tc_s, wrap_s;

    // Stimulus for the 8-bit instance.
    logic       en8, up8, load8;
    logic [7:0] load_bin8;
    logic [7:0] gray8, bin8;
    logic       valid8, tc8, wrap8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_counter_conv #(.WIDTH(4), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .gray_out(gray_w), .bin_out(bin_w), .bin_valid(valid_w), .tc(tc_w), .wrap_pulse(wrap_w)
    );

    gray_counter_conv #(.WIDTH(4), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .gray_out(gray_s), .bin_out(bin_s), .bin_valid(valid_s), .tc(tc_s), .wrap_pulse(wrap_s)
    );

    gray_counter_conv #(.WIDTH(8), .WRAP(1'b1)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .up_dn(up8), .load(load8), .load_bin(load_bin8),
        .gray_out(gray8), .bin_out(bin8), .bin_valid(valid8), .tc(tc8), .wrap_pulse(wrap8)
    );

    // Gray code of a position, straight from the x ^ (x>>1) definition.
    function automatic int ref_gray(input int n);
        return n ^ (n >> 1);
    endfunction

    // Position of a Gray code, found by searching for the value that encodes to it.
    function automatic int ref_decode(input logic [7:0] g);
        for (int n = 0; n < 256; n++) begin
            if (ref_gray(n) == int'(g)) return n;
        end
        return -1;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_bin = 4'h0;
        en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_bin8 = 8'h00;
        tick();
        tick();
        checks++;
        if (gray_w !== 4'h0 || bin_w !== 4'h0 || valid_w !== 1'b0 || wrap_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got gray=%b bin=%b valid=%b wrap=%b, want 0000/0000/0/0",
                     gray_w, bin_w, valid_w, wrap_w);
        end
        checks++;
        if (tc_w !== 1'b1) begin
            failures++;
            $display("FAIL reset_tc_down: got %b want 1", tc_w);
        end
        up_dn = 1'b1;
        #1;
        checks++;
        if (tc_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_tc_up: got %b want 0", tc_w);
        end
        rst = 1'b0;
    endtask

    // Full up-count through all 16 codes, ending with the wrap back to zero.
    task automatic test_count_up();
        logic [3:0] seq [16];
        logic [3:0] prev;
        seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        en = 1'b1; up_dn = 1'b1; load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            prev = gray_w;
            tick();
            checks++;
            if (gray_w !== seq[k % 16]) begin
                failures++;
                $display("FAIL count_up_step%0d: got %b want %b", k, gray_w, seq[k % 16]);
            end
            checks++;
            if ($countones(gray_w ^ prev) != 1) begin
                failures++;
                $display("FAIL single_bit_step%0d: %b -> %b", k, prev, gray_w);
            end
            checks++;
            if (tc_w !== (k == 15)) begin
                failures++;
                $display("FAIL tc_step%0d: got %b want %b", k, tc_w, (k == 15));
            end
            checks++;
            if (wrap_w !== (k == 16)) begin
                failures++;
                $display("FAIL wrap_step%0d: got %b want %b", k, wrap_w, (k == 16));
            end
        end
    endtask

    // Five counts then a hold: readback catches up one cycle later.
    task automatic test_hold_readback();
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (gray_w !== 4'b0111 || valid_w !== 1'b0) begin
            failures++;
            $display("FAIL count5: got gray=%b valid=%b want 0111/0", gray_w, valid_w);
        end
        checks++;
        if (bin_w !== 4'b0100) begin
            failures++;
            $display("FAIL lag_readback: got %b want 0100", bin_w);
        end
        en = 1'b0;
        tick();
        checks++;
        if (gray_w !== 4'b0111 || bin_w !== 4'b0101 || valid_w !== 1'b1) begin
            failures++;
            $display("FAIL hold_readback: got gray=%b bin=%b valid=%b want 0111/0101/1",
                     gray_w, bin_w, valid_w);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_bin = 4'b1010; en = 1'b1; up_dn = 1'b1;
        tick();
        checks++;
        if (gray_w !== 4'b1111) begin
            failures++;
            $display("FAIL load_1010: got %b want 1111", gray_w);
        end
        load = 1'b0; up_dn = 1'b0;
        tick();
        checks++;
        if (gray_w !== 4'b1101) begin
            failures++;
            $display("FAIL down_1: got %b want 1101", gray_w);
        end
        tick();
        checks++;
        if (gray_w !== 4'b1100 || wrap_w !== 1'b0) begin
            failures++;
            $display("FAIL down_2: got gray=%b wrap=%b want 1100/0", gray_w, wrap_w);
        end
    endtask

    // Saturating instance holds at both ends; the wrapping one wraps 0 -> max going down.
    task automatic test_saturate();
        load = 1'b1; load_bin = 4'b1110; en = 1'b1; up_dn = 1'b1;
        tick();
        checks++;
        if (gray_s !== 4'b1001) begin
            failures++;
            $display("FAIL sat_load: got %b want 1001", gray_s);
        end
        load = 1'b0;
        tick();
        checks++;
        if (gray_s !== 4'b1000 || tc_s !== 1'b1) begin
            failures++;
            $display("FAIL sat_top: got gray=%b tc=%b want 1000/1", gray_s, tc_s);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (gray_s !== 4'b1000 || tc_s !== 1'b1 || wrap_s !== 1'b0) begin
                failures++;
                $display("FAIL sat_hold_up%0d: got gray=%b tc=%b wrap=%b want 1000/1/0",
                         k, gray_s, tc_s, wrap_s);
            end
        end
        checks++;
        if (valid_s !== 1'b1 || bin_s !== 4'b1111) begin
            failures++;
            $display("FAIL sat_readback: got bin=%b valid=%b want 1111/1", bin_s, valid_s);
        end
        load = 1'b1; load_bin = 4'b0000;
        tick();
        load = 1'b0; up_dn = 1'b0;
        tick();
        checks++;
        if (gray_w !== 4'b1000 || wrap_w !== 1'b1) begin
            failures++;
            $display("FAIL wrap_down: got gray=%b wrap=%b want 1000/1", gray_w, wrap_w);
        end
        tick();
        checks++;
        if (gray_s !== 4'b0000 || tc_s !== 1'b1 || wrap_s !== 1'b0) begin
            failures++;
            $display("FAIL sat_hold_down: got gray=%b tc=%b wrap=%b want 0000/1/0",
                     gray_s, tc_s, wrap_s);
        end
    endtask

    // Reset lands between edges and must clear the outputs without waiting for a clock.
    task automatic test_reset_mid_count();
        load = 1'b1; load_bin = 4'b0000; en = 1'b0; up_dn = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (gray_w !== 4'b0110) begin
            failures++;
            $display("FAIL pre_reset: got %b want 0110", gray_w);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gray_w !== 4'h0 || bin_w !== 4'h0 || valid_w !== 1'b0 || wrap_w !== 1'b0 || tc_w !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: got gray=%b bin=%b valid=%b wrap=%b tc=%b want 0000/0000/0/0/0",
                     gray_w, bin_w, valid_w, wrap_w, tc_w);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (gray_w !== 4'b0001) begin
            failures++;
            $display("FAIL first_after_reset: got %b want 0001", gray_w);
        end
        en = 1'b0;
    endtask

    // 8-bit randomized run against a model that tracks only the counter position.
    task automatic test_random8();
        int pos, old_pos;
        bit exp_wrap;
        logic [7:0] prev_gray;
        pos = ref_decode(8'h00);
        for (int i = 0; i < 1000; i++) begin
            en8       = 1'($urandom_range(0, 3) != 0);
            up8       = 1'($urandom_range(0, 1));
            load8     = 1'($urandom_range(0, 15) == 0);
            load_bin8 = 8'($urandom_range(0, 255));
            if (i % 97 == 0) load_bin8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            #1;
            checks++;
            if (tc8 !== (up8 ? (pos == 255) : (pos == 0))) begin
                failures++;
                $display("FAIL rnd_tc[%0d]: got %b pos=%0d up=%b", i, tc8, pos, up8);
            end
            old_pos  = pos;
            exp_wrap = 1'b0;
            if (load8) begin
                pos = int'(load_bin8);
            end else if (en8) begin
                if (up8) begin
                    exp_wrap = (pos == 255);
                    pos = (pos + 1) % 256;
                end else begin
                    exp_wrap = (pos == 0);
                    pos = (pos + 255) % 256;
                end
            end
            prev_gray = gray8;
            tick();
            checks++;
            if (ref_decode(gray8) != pos) begin
                failures++;
                $display("FAIL rnd_state[%0d]: decoded %0d want %0d", i, ref_decode(gray8), pos);
            end
            checks++;
            if (int'(bin8) != old_pos || valid8 !== (pos == old_pos)) begin
                failures++;
                $display("FAIL rnd_readback[%0d]: got bin=%0d valid=%b want %0d/%b",
                         i, bin8, valid8, old_pos, (pos == old_pos));
            end
            checks++;
            if (wrap8 !== exp_wrap) begin
                failures++;
                $display("FAIL rnd_wrap[%0d]: got %b want %b", i, wrap8, exp_wrap);
            end
            if (!load8) begin
                checks++;
                if ($countones(gray8 ^ prev_gray) != ((pos != old_pos) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL rnd_one_bit[%0d]: %b -> %b", i, prev_gray, gray8);
                end
            end
        end
        en8 = 1'b0; load8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_hold_readback();
        test_load_priority();
        test_saturate();
        test_reset_mid_count();
        test_random8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
